enc_time_set_ctrl: RTL and testbench



---
 rtl/enc_time_set_ctrl_pkg.sv | 18 +
 rtl/enc_time_set_ctrl_if.sv | 22 ++
 rtl/enc_time_set_ctrl_bcd_wrap_step.sv | 16 +
 rtl/enc_time_set_ctrl.sv | 137 +++++++++++++
 tb/tb_enc_time_set_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/enc_time_set_ctrl_pkg.sv
// Shared types and constants for the encoder-driven MM:SS preset editor.
package enc_set_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] SEL_MIN_T = 2'd3;
  localparam logic [1:0] SEL_MIN_O = 2'd2;
  localparam logic [1:0] SEL_SEC_T = 2'd1;
  localparam logic [1:0] SEL_SEC_O = 2'd0;

  // Indexed by digit select: tens digits roll over at 5, ones digits at 9.
  localparam logic [3:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9};

endpackage

// File: rtl/enc_time_set_ctrl_if.sv
// Encoder front-end / stopwatch-facing signal bundle for the preset editor.
interface enc_time_set_ctrl_if;
  logic        inc_pulse;
  logic        dec_pulse;
  logic        btn_press;
  logic        run_active;
  logic [15:0] set_value;
  logic        edit_en;
  logic [1:0]  edit_sel;
  logic        blank;
  logic        load_pulse;

  modport master (
    output inc_pulse, dec_pulse, btn_press, run_active,
    input  set_value, edit_en, edit_sel, blank, load_pulse
  );

  modport slave (
    input  inc_pulse, dec_pulse, btn_press, run_active,
    output set_value, edit_en, edit_sel, blank, load_pulse
  );
endinterface

// File: rtl/enc_time_set_ctrl_bcd_wrap_step.sv
// One-digit BCD up/down step with wrap at 0 and at the digit's maximum.
module bcd_wrap_step (
  input  logic [3:0] digit,
  input  logic [3:0] max,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] next
);
  always_comb begin
    next = digit;
    if (inc && !dec)
      next = (digit == max) ? 4'd0 : digit + 4'd1;
    else if (dec && !inc)
      next = (digit == 4'd0) ? max : digit - 4'd1;
  end
endmodule

// File: rtl/enc_time_set_ctrl.sv
// Rotary-encoder preset editor: per-digit MM:SS edit with blinking cursor and load strobe.
module enc_time_set_ctrl
  import enc_set_pkg::*;
#(
  parameter int TIMEOUT_CYC = 500000000,
  parameter int BLINK_HALF  = 25000000
) (
  input logic                clk,
  input logic                reset,
  enc_time_set_ctrl_if.slave bus
);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam int BLK_W = $clog2(BLINK_HALF);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  state_t             state;
  logic [15:0]        set_value;
  logic [15:0]        shadow;
  logic               edit_en;
  logic [1:0]         sel;
  logic               blank;
  logic               load_pulse;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [BLK_W-1:0]   blk_cnt;

  logic [3:0]         cur_digit;
  logic [3:0]         step_digit;
  logic [15:0]        stepped;
  logic               turn;
  logic               activity;

  assign turn      = bus.inc_pulse | bus.dec_pulse;
  assign activity  = turn | bus.btn_press;
  assign cur_digit = set_value[{sel, 2'b00} +: 4];

  bcd_wrap_step u_step (
    .digit (cur_digit),
    .max   (DIGIT_MAX[sel]),
    .inc   (bus.inc_pulse),
    .dec   (bus.dec_pulse),
    .next  (step_digit)
  );

  always_comb begin
    stepped = set_value;
    stepped[{sel, 2'b00} +: 4] = step_digit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      set_value  <= '0;
      shadow     <= '0;
      edit_en    <= 1'b0;
      sel        <= SEL_MIN_T;
      blank      <= 1'b0;
      load_pulse <= 1'b0;
      tmo_cnt    <= '0;
      blk_cnt    <= '0;
    end else begin
      load_pulse <= 1'b0;
      case (state)
        IDLE: begin
          edit_en <= 1'b0;
          blank   <= 1'b0;
          sel     <= SEL_MIN_T;
          tmo_cnt <= '0;
          blk_cnt <= '0;
          if (bus.btn_press && !bus.run_active) begin
            state   <= EDIT;
            edit_en <= 1'b1;
          end
        end

        EDIT: begin
          // Stopwatch start or inactivity drops the edit and restores the committed preset.
          if (bus.run_active || (!activity && tmo_cnt == TMO_LAST)) begin
            state     <= IDLE;
            set_value <= shadow;
            edit_en   <= 1'b0;
            sel       <= SEL_MIN_T;
            blank     <= 1'b0;
            tmo_cnt   <= '0;
            blk_cnt   <= '0;
          end else begin
            set_value <= stepped;

            if (activity)
              tmo_cnt <= '0;
            else if (tmo_cnt != TMO_LAST)
              tmo_cnt <= tmo_cnt + TMO_W'(1);

            // Any user action snaps the cursor to its visible phase.
            if (activity) begin
              blk_cnt <= '0;
              blank   <= 1'b0;
            end else if (blk_cnt == BLK_LAST) begin
              blk_cnt <= '0;
              blank   <= ~blank;
            end else begin
              blk_cnt <= blk_cnt + BLK_W'(1);
            end

            if (bus.btn_press) begin
              if (sel != SEL_SEC_O) begin
                sel <= sel - 2'd1;
              end else begin
                state      <= COMMIT;
                load_pulse <= 1'b1;
                edit_en    <= 1'b0;
              end
            end
          end
        end

        COMMIT: begin
          shadow  <= set_value;
          state   <= IDLE;
          sel     <= SEL_MIN_T;
          blank   <= 1'b0;
          tmo_cnt <= '0;
          blk_cnt <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.set_value  = set_value;
  assign bus.edit_en    = edit_en;
  assign bus.edit_sel   = sel;
  assign bus.blank      = blank;
  assign bus.load_pulse = load_pulse;

endmodule

// File: tb/tb_enc_time_set_ctrl.sv
// Scoreboard bench for the preset editor with short timeout and blink periods.
module tb_enc_time_set_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  enc_time_set_ctrl_if bus_if ();

  enc_time_set_ctrl #(.TIMEOUT_CYC(50), .BLINK_HALF(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // Reference model: 0 idle, 1 edit, 2 commit
  int          m_state;
  logic [15:0] m_val;
  logic [15:0] m_shadow;
  logic [1:0]  m_sel;

  function automatic logic [3:0] ref_max(input logic [1:0] s);
    return (s == 2'd3 || s == 2'd1) ? 4'd5 : 4'd9;
  endfunction

  // Drive one clock of inputs (called at a negedge) and advance the model.
  task automatic step(input logic i, input logic d, input logic b);
    int idx;
    logic [3:0] dg;
    logic [3:0] mx;
    bus_if.inc_pulse = i;
    bus_if.dec_pulse = d;
    bus_if.btn_press = b;
    case (m_state)
      0: if (b && !bus_if.run_active) begin m_state = 1; m_sel = 2'd3; end
      1: begin
        if (bus_if.run_active) begin
          m_val = m_shadow; m_state = 0; m_sel = 2'd3;
        end else begin
          idx = int'(m_sel);
          dg  = m_val[idx*4 +: 4];
          mx  = ref_max(m_sel);
          if (i && !d)      dg = (dg == mx) ? 4'd0 : dg + 4'd1;
          else if (d && !i) dg = (dg == 4'd0) ? mx : dg - 4'd1;
          m_val[idx*4 +: 4] = dg;
          if (b) begin
            if (m_sel != 2'd0) m_sel = m_sel - 2'd1;
            else begin m_state = 2; exp_q.push_back(m_val); end
          end
        end
      end
      default: begin m_shadow = m_val; m_state = 0; m_sel = 2'd3; end
    endcase
    @(negedge clk);
    bus_if.inc_pulse = 1'b0;
    bus_if.dec_pulse = 1'b0;
    bus_if.btn_press = 1'b0;
  endtask

  // Load strobes are popped against the values queued when the commit was driven.
  always @(negedge clk) begin
    logic [15:0] e;
    if (reset === 1'b0 && bus_if.load_pulse === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL load_unexpected got set_value=%h required no load_pulse", bus_if.set_value);
      end else begin
        e = exp_q.pop_front();
        if (bus_if.set_value !== e) begin
          n_err++;
          $display("FAIL load_value got %h required %h", bus_if.set_value, e);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    bus_if.inc_pulse = 0; bus_if.dec_pulse = 0; bus_if.btn_press = 0; bus_if.run_active = 0;
    m_state = 0; m_val = '0; m_shadow = '0; m_sel = 2'd3;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (bus_if.set_value !== 16'h0000) begin n_err++; $display("FAIL rst_set_value got %h required 0000", bus_if.set_value); end
    n_cmp++; if (bus_if.edit_en !== 1'b0) begin n_err++; $display("FAIL rst_edit_en got %b required 0", bus_if.edit_en); end
    n_cmp++; if (bus_if.edit_sel !== 2'd3) begin n_err++; $display("FAIL rst_edit_sel got %0d required 3", bus_if.edit_sel); end
    n_cmp++; if (bus_if.blank !== 1'b0) begin n_err++; $display("FAIL rst_blank got %b required 0", bus_if.blank); end
    n_cmp++; if (bus_if.load_pulse !== 1'b0) begin n_err++; $display("FAIL rst_load got %b required 0", bus_if.load_pulse); end
  endtask

  task automatic test_full_edit();
    step(0, 0, 1);
    n_cmp++; if (bus_if.edit_en !== 1'b1 || bus_if.edit_sel !== 2'd3) begin n_err++; $display("FAIL enter_edit got en=%b sel=%0d required en=1 sel=3", bus_if.edit_en, bus_if.edit_sel); end
    repeat (3) step(1, 0, 0);
    step(0, 0, 1);
    repeat (12) step(1, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    repeat (2) step(0, 1, 0);
    step(0, 0, 1);
    n_cmp++; if (bus_if.edit_en !== 1'b0) begin n_err++; $display("FAIL commit_edit_en got %b required 0", bus_if.edit_en); end
    step(0, 0, 0);
    n_cmp++; if (bus_if.set_value !== 16'h3208 || bus_if.load_pulse !== 1'b0) begin n_err++; $display("FAIL full_edit got %h load=%b required 3208 load=0", bus_if.set_value, bus_if.load_pulse); end
  endtask

  task automatic test_wrap();
    step(0, 0, 1);
    repeat (2) step(1, 0, 0);
    step(1, 0, 0);
    n_cmp++; if (bus_if.set_value[15:12] !== 4'd0) begin n_err++; $display("FAIL wrap_inc_5 got %0d required 0", bus_if.set_value[15:12]); end
    step(0, 1, 0);
    n_cmp++; if (bus_if.set_value[15:12] !== 4'd5) begin n_err++; $display("FAIL wrap_dec_0 got %0d required 5", bus_if.set_value[15:12]); end
    step(0, 0, 1);
    repeat (2) step(0, 1, 0);
    step(0, 1, 0);
    n_cmp++; if (bus_if.set_value[11:8] !== 4'd9) begin n_err++; $display("FAIL wrap_dec_ones got %0d required 9", bus_if.set_value[11:8]); end
    repeat (3) step(0, 0, 1);
    step(0, 0, 0);
    n_cmp++; if (bus_if.set_value !== 16'h5908) begin n_err++; $display("FAIL wrap_commit got %h required 5908", bus_if.set_value); end
  endtask

  task automatic test_timeout();
    step(0, 0, 1);
    repeat (2) step(1, 0, 0);
    n_cmp++; if (bus_if.set_value !== 16'h1908) begin n_err++; $display("FAIL tmo_edit got %h required 1908", bus_if.set_value); end
    repeat (45) step(0, 0, 0);
    n_cmp++; if (bus_if.edit_en !== 1'b1) begin n_err++; $display("FAIL tmo_early got edit_en=%b required 1", bus_if.edit_en); end
    repeat (5) step(0, 0, 0);
    m_state = 0; m_val = m_shadow; m_sel = 2'd3;
    n_cmp++; if (bus_if.edit_en !== 1'b0 || bus_if.set_value !== 16'h5908) begin n_err++; $display("FAIL tmo_abort got en=%b val=%h required en=0 val=5908", bus_if.edit_en, bus_if.set_value); end
  endtask

  task automatic test_run_abort();
    step(0, 0, 1);
    n_cmp++; if (bus_if.edit_en !== 1'b1) begin n_err++; $display("FAIL run_enter got %b required 1", bus_if.edit_en); end
    bus_if.run_active = 1'b1;
    step(1, 0, 0);
    n_cmp++; if (bus_if.edit_en !== 1'b0 || bus_if.set_value !== 16'h5908) begin n_err++; $display("FAIL run_abort got en=%b val=%h required en=0 val=5908", bus_if.edit_en, bus_if.set_value); end
    step(0, 0, 1);
    n_cmp++; if (bus_if.edit_en !== 1'b0) begin n_err++; $display("FAIL run_idle_btn got %b required 0", bus_if.edit_en); end
    bus_if.run_active = 1'b0;
  endtask

  task automatic test_same_cycle();
    step(0, 0, 1);
    repeat (40) step(0, 0, 0);
    step(1, 1, 0);
    n_cmp++; if (bus_if.set_value !== 16'h5908) begin n_err++; $display("FAIL incdec_value got %h required 5908", bus_if.set_value); end
    repeat (40) step(0, 0, 0);
    n_cmp++; if (bus_if.edit_en !== 1'b1) begin n_err++; $display("FAIL incdec_tmo_restart got edit_en=%b required 1", bus_if.edit_en); end
    repeat (3) step(0, 0, 1);
    n_cmp++; if (bus_if.edit_sel !== 2'd0) begin n_err++; $display("FAIL sel_walk got %0d required 0", bus_if.edit_sel); end
    step(1, 0, 1);
    n_cmp++; if (bus_if.load_pulse !== 1'b1 || bus_if.set_value !== 16'h5909 || bus_if.edit_en !== 1'b0) begin n_err++; $display("FAIL btn_inc_commit got load=%b val=%h en=%b required load=1 val=5909 en=0", bus_if.load_pulse, bus_if.set_value, bus_if.edit_en); end
    step(0, 0, 0);
    n_cmp++; if (bus_if.load_pulse !== 1'b0) begin n_err++; $display("FAIL load_width got %b required 0", bus_if.load_pulse); end
  endtask

  task automatic test_blink();
    logic eb;
    step(0, 0, 1);
    for (int k = 0; k <= 6; k++) begin
      eb = ((k / 4) % 2) == 1;
      n_cmp++; if (bus_if.blank !== eb) begin n_err++; $display("FAIL blink_k%0d got %b required %b", k, bus_if.blank, eb); end
      if (k < 6) step(0, 0, 0);
    end
    step(1, 0, 0);
    n_cmp++; if (bus_if.blank !== 1'b0) begin n_err++; $display("FAIL blink_restart got %b required 0", bus_if.blank); end
    bus_if.run_active = 1'b1;
    step(0, 0, 0);
    bus_if.run_active = 1'b0;
    n_cmp++; if (bus_if.blank !== 1'b0 || bus_if.set_value !== 16'h5909) begin n_err++; $display("FAIL blink_abort got blank=%b val=%h required blank=0 val=5909", bus_if.blank, bus_if.set_value); end
  endtask

  initial begin
    test_reset();
    test_full_edit();
    test_wrap();
    test_timeout();
    test_run_abort();
    test_same_cycle();
    test_blink();
    repeat (3) step(0, 0, 0);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL loads_missing got %0d pending required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
